// File: rtl/mul_share_sched_if.sv
// ---------------------------------------------------------------------------
// mul_share_sched_if
//   Bundles the requester handshake, the multiplier issue/return bus and the
//   scheduler status signals. clk/rst are kept outside as plain ports.
//
//   slave  : the scheduler side (takes requests and products, drives grants,
//            operands, responses and status)
//   master : the environment side (requesters plus the multiplier instance)
//
//   sched_en     grants allowed when 1
//   req_valid    per-requester operand-pair valid
//   req_ready    one-hot grant
//   req_a/req_b  flattened operands, lane i at [i*DATAWIDTH +: DATAWIDTH]
//   mul_i_valid  issue strobe to the multiplier
//   mul_a/mul_b  operands to the multiplier
//   mul_o_valid  multiplier result valid
//   mul_result   multiplier product
//   rsp_valid    one-hot result strobe to the owning requester
//   rsp_data     product on a shared bus
//   in_flight    ops issued and not yet responded
//   err_tag      sticky tag/result disagreement flag
// ---------------------------------------------------------------------------
interface mul_share_sched_if #(
  parameter int DATAWIDTH = 16,
  parameter int NUM_REQ   = 4,
  parameter int LATENCY   = 10
);
  localparam int CNT_W = $clog2(LATENCY + 3);

  logic                         sched_en;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*DATAWIDTH-1:0] req_a;
  logic [NUM_REQ*DATAWIDTH-1:0] req_b;
  logic                         mul_i_valid;
  logic [DATAWIDTH-1:0]         mul_a;
  logic [DATAWIDTH-1:0]         mul_b;
  logic                         mul_o_valid;
  logic [DATAWIDTH-1:0]         mul_result;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [DATAWIDTH-1:0]         rsp_data;
  logic [CNT_W-1:0]             in_flight;
  logic                         err_tag;

  modport slave (
    input  sched_en, req_valid, req_a, req_b, mul_o_valid, mul_result,
    output req_ready, mul_i_valid, mul_a, mul_b, rsp_valid, rsp_data,
           in_flight, err_tag
  );

  modport master (
    output sched_en, req_valid, req_a, req_b, mul_o_valid, mul_result,
    input  req_ready, mul_i_valid, mul_a, mul_b, rsp_valid, rsp_data,
           in_flight, err_tag
  );
endinterface

// File: rtl/mul_share_sched.sv
// ---------------------------------------------------------------------------
// mul_share_sched
//   Round-robin scheduler sharing one pipelined fixed-point multiplier among
//   NUM_REQ requesters. One operand pair is granted per cycle, registered onto
//   the multiplier inputs, and the requester id travels alongside through a
//   LATENCY-deep tag pipe so each product returns to its issuer.
//
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous reset, active-low
//     bus   mul_share_sched_if.slave (requests, multiplier bus, responses,
//           in_flight counter, sticky err_tag)
//
//   Timing: handshake in cycle c -> mul_i_valid in c+1 -> product expected
//   from the multiplier in c+1+LATENCY -> rsp_valid in c+2+LATENCY.
// ---------------------------------------------------------------------------
module mul_share_sched #(
  parameter int DATAWIDTH = 16,
  parameter int FRAC_BITS = 8,
  parameter int NUM_REQ   = 4,
  parameter int LATENCY   = 10
) (
  input  logic             clk,
  input  logic             rst,
  mul_share_sched_if.slave bus
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(LATENCY + 3);
  localparam int TAG_W = PTR_W + 1;

  // Elaboration-time parameter sanity.
  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("mul_share_sched: NUM_REQ must be >= 2");
  end
  if (LATENCY < 0) begin : g_bad_latency
    $error("mul_share_sched: LATENCY must be >= 0");
  end
  if (FRAC_BITS < 0 || FRAC_BITS >= DATAWIDTH) begin : g_bad_frac
    $error("mul_share_sched: FRAC_BITS must lie in [0, DATAWIDTH)");
  end

  // Unpacked view of the flattened operand buses.
  logic [DATAWIDTH-1:0] w_lane_a [NUM_REQ];
  logic [DATAWIDTH-1:0] w_lane_b [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign w_lane_a[g] = bus.req_a[g*DATAWIDTH +: DATAWIDTH];
    assign w_lane_b[g] = bus.req_b[g*DATAWIDTH +: DATAWIDTH];
  end

  logic [PTR_W-1:0]     r_ptr;
  logic [NUM_REQ-1:0]   w_grant;
  logic [PTR_W-1:0]     w_grant_id;
  logic [PTR_W-1:0]     w_idx;
  logic                 w_hs;
  int                   w_sum;

  // ---- grant stage (combinational) ----
  // Search starts one past the last winner and wraps. The grant is held off
  // while reset is asserted so req_ready reads 0 along with every other
  // output. mul_o_valid is deliberately absent from this cone.
  always_comb begin
    w_grant    = '0;
    w_grant_id = '0;
    w_hs       = 1'b0;
    w_idx      = '0;
    w_sum      = 0;
    if (rst && bus.sched_en) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        w_sum = int'(r_ptr) + k;
        if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
        w_idx = w_sum[PTR_W-1:0];
        if (!w_hs && bus.req_valid[w_idx]) begin
          w_hs             = 1'b1;
          w_grant[w_idx]   = 1'b1;
          w_grant_id       = w_idx;
        end
      end
    end
  end

  // ---- issue stage: registered operands and issuer id ----
  logic                 r_mul_i_valid;
  logic [DATAWIDTH-1:0] r_mul_a;
  logic [DATAWIDTH-1:0] r_mul_b;
  logic [PTR_W-1:0]     r_issue_id;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr         <= PTR_W'(NUM_REQ - 1);
      r_mul_i_valid <= 1'b0;
      r_mul_a       <= '0;
      r_mul_b       <= '0;
      r_issue_id    <= '0;
    end else begin
      r_mul_i_valid <= w_hs;
      if (w_hs) begin
        r_ptr      <= w_grant_id;
        r_issue_id <= w_grant_id;
        r_mul_a    <= w_lane_a[w_grant_id];
        r_mul_b    <= w_lane_b[w_grant_id];
      end
    end
  end

  // ---- tag pipe: LATENCY stages behind the issue stage ----
  logic [TAG_W-1:0] w_issue_tag;
  logic [TAG_W-1:0] w_tail_tag;
  logic             w_tail_vld;
  logic [PTR_W-1:0] w_tail_id;

  assign w_issue_tag = {r_mul_i_valid, r_issue_id};

  if (LATENCY == 0) begin : g_lat0
    // Combinational multiplier: the product lines up with the issue stage.
    assign w_tail_tag = w_issue_tag;
  end else begin : g_pipe
    // Packed shift register, newest tag in the low slot, tail in the top slot.
    logic [LATENCY*TAG_W-1:0] r_tags;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_tags <= '0;
      end else begin
        r_tags <= (r_tags << TAG_W) | (LATENCY*TAG_W)'(w_issue_tag);
      end
    end

    assign w_tail_tag = r_tags[LATENCY*TAG_W-1 -: TAG_W];
  end

  assign w_tail_vld = w_tail_tag[TAG_W-1];
  assign w_tail_id  = w_tail_tag[PTR_W-1:0];

  logic [NUM_REQ-1:0] w_tail_onehot;

  always_comb begin
    w_tail_onehot            = '0;
    w_tail_onehot[w_tail_id] = 1'b1;
  end

  // ---- response stage: routing, occupancy and tag consistency ----
  logic [NUM_REQ-1:0]   r_rsp_valid;
  logic [DATAWIDTH-1:0] r_rsp_data;
  logic [CNT_W-1:0]     r_in_flight;
  logic                 r_err_tag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_in_flight <= '0;
      r_err_tag   <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      if (w_tail_vld && bus.mul_o_valid) begin
        r_rsp_valid <= w_tail_onehot;
        r_rsp_data  <= bus.mul_result;
      end
      // Any disagreement between the multiplier strobe and the tag pipe means
      // the two have lost step; the flag stays up until reset.
      if (w_tail_vld != bus.mul_o_valid) begin
        r_err_tag <= 1'b1;
      end
      // A valid tail retires whether or not the multiplier agreed, so the
      // counter only ever decrements a slot it previously counted.
      if (w_hs && !w_tail_vld) begin
        r_in_flight <= r_in_flight + CNT_W'(1);
      end else if (!w_hs && w_tail_vld) begin
        r_in_flight <= r_in_flight - CNT_W'(1);
      end
    end
  end

  assign bus.req_ready   = w_grant;
  assign bus.mul_i_valid = r_mul_i_valid;
  assign bus.mul_a       = r_mul_a;
  assign bus.mul_b       = r_mul_b;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_data    = r_rsp_data;
  assign bus.in_flight   = r_in_flight;
  assign bus.err_tag     = r_err_tag;

endmodule

// File: tb/tb_mul_share_sched.sv
// ---------------------------------------------------------------------------
// tb_mul_share_sched
//   Drives mul_share_sched through directed scenarios and randomized traffic.
//   A Q8.8 multiplier with LAT cycles of latency sits on the multiplier side.
//   The reference model keeps the last winner and a queue of pending
//   responses with their due cycle; it is checked against the DUT every cycle
//   at the falling edge. Stimulus changes 1 ns after the rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mul_share_sched;

  localparam int DW  = 16;
  localparam int FB  = 8;
  localparam int NR  = 4;
  localparam int LAT = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic inj = 1'b0;

  always #5 clk = ~clk;

  mul_share_sched_if #(.DATAWIDTH(DW), .NUM_REQ(NR), .LATENCY(LAT)) ifc();

  mul_share_sched #(
    .DATAWIDTH(DW), .FRAC_BITS(FB), .NUM_REQ(NR), .LATENCY(LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  function automatic logic [DW-1:0] qmul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [2*DW-1:0] p;
    p = $signed(a) * $signed(b);
    return p[FB+DW-1:FB];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", nm, cyc, act, exp);
    end
  endtask

  // ---- multiplier stand-in: LAT-deep pipe, flushed by reset ----
  logic          mv [LAT];
  logic [DW-1:0] md [LAT];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < LAT; j++) begin
        mv[j] <= 1'b0;
        md[j] <= '0;
      end
    end else begin
      mv[0] <= ifc.mul_i_valid;
      md[0] <= qmul(ifc.mul_a, ifc.mul_b);
      for (int j = 1; j < LAT; j++) begin
        mv[j] <= mv[j-1];
        md[j] <= md[j-1];
      end
    end
  end

  assign ifc.mul_o_valid = mv[LAT-1] | inj;
  assign ifc.mul_result  = md[LAT-1];

  // ---- reference model and per-cycle compare ----
  typedef struct {
    int          due;
    int          lane;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          rq[$];
  int            m_ptr = NR - 1;
  logic          m_miv = 1'b0;
  logic [DW-1:0] m_ma  = '0;
  logic [DW-1:0] m_mb  = '0;
  logic          m_err = 1'b0;

  always @(negedge clk) begin
    logic [NR-1:0] eg;
    logic [NR-1:0] erv;
    logic [DW-1:0] erd;
    int            gl;
    cyc++;
    if (!rst) begin
      rq.delete();
      m_ptr = NR - 1;
      m_miv = 1'b0;
      m_ma  = '0;
      m_mb  = '0;
      m_err = 1'b0;
      chk("rst_req_ready",   ifc.req_ready,   0);
      chk("rst_mul_i_valid", ifc.mul_i_valid, 0);
      chk("rst_mul_a",       ifc.mul_a,       0);
      chk("rst_mul_b",       ifc.mul_b,       0);
      chk("rst_rsp_valid",   ifc.rsp_valid,   0);
      chk("rst_rsp_data",    ifc.rsp_data,    0);
      chk("rst_in_flight",   ifc.in_flight,   0);
      chk("rst_err_tag",     ifc.err_tag,     0);
    end else begin
      erv = '0;
      erd = '0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        erv[rq[0].lane] = 1'b1;
        erd = rq[0].data;
        void'(rq.pop_front());
      end
      chk("rsp_valid", ifc.rsp_valid, erv);
      if (erv != '0) chk("rsp_data", ifc.rsp_data, erd);
      chk("in_flight",   ifc.in_flight,   rq.size());
      chk("mul_i_valid", ifc.mul_i_valid, m_miv);
      chk("mul_a",       ifc.mul_a,       m_ma);
      chk("mul_b",       ifc.mul_b,       m_mb);
      chk("err_tag",     ifc.err_tag,     m_err);

      // First valid requester after the previous winner, wrapping around.
      gl = -1;
      if (ifc.sched_en) begin
        for (int k = 1; k <= NR; k++) begin
          if (gl < 0 && ifc.req_valid[(m_ptr + k) % NR]) gl = (m_ptr + k) % NR;
        end
      end
      eg = '0;
      if (gl >= 0) eg[gl] = 1'b1;
      chk("req_ready", ifc.req_ready, eg);

      m_miv = (gl >= 0);
      if (gl >= 0) begin
        m_ptr = gl;
        m_ma  = ifc.req_a[gl*DW +: DW];
        m_mb  = ifc.req_b[gl*DW +: DW];
        rq.push_back('{cyc + LAT + 2, gl, qmul(m_ma, m_mb)});
      end
      if (inj) m_err = 1'b1;
    end
  end

  // ---- stimulus ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    for (int l = 0; l < NR; l++) begin
      ifc.req_a[l*DW +: DW] = DW'($urandom);
      ifc.req_b[l*DW +: DW] = DW'($urandom);
    end
  endtask

  initial begin
    ifc.sched_en  = 1'b0;
    ifc.req_valid = '0;
    ifc.req_a     = '0;
    ifc.req_b     = '0;
    rst           = 1'b0;
    repeat (3) tick();
    rst          = 1'b1;
    ifc.sched_en = 1'b1;

    // All requesters valid: strict rotation starting at lane 0.
    for (int k = 0; k < 8; k++) begin
      ifc.req_valid = 4'b1111;
      rand_ops();
      @(negedge clk);
      chk("rr_order", ifc.req_ready, 64'd1 << (k % 4));
      tick();
    end
    ifc.req_valid = '0;
    repeat (14) tick();

    // Single product with known operands: 2.0 * 3.0 = 6.0.
    ifc.req_a[1*DW +: DW] = 16'h0200;
    ifc.req_b[1*DW +: DW] = 16'h0300;
    ifc.req_valid = 4'b0010;
    @(negedge clk);
    chk("lane1_grant", ifc.req_ready, 4'b0010);
    tick();
    ifc.req_valid = '0;
    repeat (10) tick();
    @(negedge clk);
    chk("lane1_not_early", ifc.rsp_valid, 0);
    tick();
    @(negedge clk);
    chk("lane1_rsp_valid", ifc.rsp_valid, 4'b0010);
    chk("lane1_rsp_data",  ifc.rsp_data,  16'h0600);
    repeat (13) tick();

    // Lone requester gets every slot.
    for (int k = 0; k < 5; k++) begin
      ifc.req_valid = 4'b0100;
      rand_ops();
      @(negedge clk);
      chk("lane2_streak", ifc.req_ready, 4'b0100);
      tick();
    end
    ifc.req_valid = '0;
    @(negedge clk);
    chk("lane2_in_flight", ifc.in_flight, 5);
    repeat (6) tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      @(negedge clk);
      chk("lane2_b2b_rsp", ifc.rsp_valid, 4'b0100);
    end
    repeat (4) tick();

    // Scheduling disabled after three grants: in-flight ops still drain.
    ifc.req_valid = 4'b1111;
    rand_ops();
    repeat (3) tick();
    ifc.sched_en = 1'b0;
    @(negedge clk);
    chk("en_off_no_grant", ifc.req_ready, 0);
    chk("en_off_in_flight", ifc.in_flight, 3);
    repeat (16) tick();
    @(negedge clk);
    chk("en_off_drained", ifc.in_flight, 0);
    tick();
    ifc.req_valid = '0;
    ifc.sched_en  = 1'b1;
    repeat (3) tick();

    // Spurious multiplier strobe with an empty tag pipe.
    inj = 1'b1;
    tick();
    inj = 1'b0;
    @(negedge clk);
    chk("err_set",    ifc.err_tag,   1);
    chk("err_no_rsp", ifc.rsp_valid, 0);
    repeat (5) tick();
    @(negedge clk);
    chk("err_sticky", ifc.err_tag, 1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("err_cleared", ifc.err_tag, 0);
    tick();
    rst = 1'b1;

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      ifc.req_valid = ($urandom_range(0, 3) == 0) ? NR'($urandom) : 4'b1111 & NR'($urandom | $urandom);
      ifc.sched_en  = ($urandom_range(0, 7) != 0);
      rand_ops();
      tick();
    end
    ifc.req_valid = '0;
    ifc.sched_en  = 1'b1;
    repeat (14) tick();

    // Reset with six ops in flight: they vanish, lane 0 wins next.
    ifc.req_valid = 4'b1111;
    rand_ops();
    repeat (6) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_flight", ifc.in_flight,   0);
    chk("midrst_req_ready", ifc.req_ready,   0);
    chk("midrst_mul_valid", ifc.mul_i_valid, 0);
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_grant", ifc.req_ready, 4'b0001);
    tick();
    ifc.req_valid = '0;
    repeat (16) tick();
    @(negedge clk);
    chk("post_rst_drained", ifc.in_flight, 0);
    chk("post_rst_no_err",  ifc.err_tag,   0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
